// File: rtl/hazard_stall_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared state encoding and register constants for the
//                 pipeline sequencer.   Rev 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MC_WAIT  = 2'd2
  } state_e;

  localparam logic [4:0] X0_IDX = 5'd0;

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones instead of wrapping.
//               Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// hazard_stall_ctrl : 5-stage pipe sequencer - load-use stalls, branch
//                     flushes, multi-cycle EX holds, memory freeze. Rev 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             branch_taken,
  input  logic             mc_start,
  input  logic             mc_done,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] LU_RELOAD = 2'(LOAD_STALL_CYC - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lu_hazard;
  logic       flush_inc;

  assign lu_hazard = ex_MemRead && (ex_rd != X0_IDX) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    flush_inc     = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;

    if (reset) begin
      state_d = ST_RUN;
      cnt_d   = 2'd0;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (mc_start) begin
            // Result already valid in the issue cycle: no hold at all.
            if (!mc_done) begin
              pc_write      = 1'b0;
              if_id_write   = 1'b0;
              id_ex_write   = 1'b0;
              ex_mem_bubble = 1'b1;
              state_d       = ST_MC_WAIT;
            end
          end else if (lu_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = ST_LU_STALL;
              cnt_d   = LU_RELOAD;
            end
          end
        end
        ST_LU_STALL: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = 2'd0;
          end else begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            cnt_d       = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
              state_d = ST_RUN;
              cnt_d   = 2'd0;
            end
          end
        end
        ST_MC_WAIT: begin
          if (mc_done) begin
            state_d = ST_RUN;
          end else begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (~pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (flush_inc),
    .count (flush_events)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// tb_hazard_stall_ctrl : directed bench; dut_a LOAD_STALL_CYC=1/CNT_W=32,
//                        dut_b LOAD_STALL_CYC=2/CNT_W=3 on shared inputs.
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_MemRead, branch_taken, mc_start, mc_done, mem_busy;

  logic        a_pc_w, a_ifid_w, a_ifid_f, a_idex_w, a_idex_f, a_bub;
  logic [1:0]  a_st;
  logic [31:0] a_stall, a_flush;
  logic        b_pc_w, b_ifid_w, b_ifid_f, b_idex_w, b_idex_f, b_bub;
  logic [1:0]  b_st;
  logic [2:0]  b_stall, b_flush;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .branch_taken(branch_taken), .mc_start(mc_start), .mc_done(mc_done),
    .mem_busy(mem_busy), .pc_write(a_pc_w), .if_id_write(a_ifid_w),
    .if_id_flush(a_ifid_f), .id_ex_write(a_idex_w), .id_ex_flush(a_idex_f),
    .ex_mem_bubble(a_bub), .state_o(a_st), .stall_cycles(a_stall),
    .flush_events(a_flush)
  );

  hazard_stall_ctrl #(.LOAD_STALL_CYC(2), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .branch_taken(branch_taken), .mc_start(mc_start), .mc_done(mc_done),
    .mem_busy(mem_busy), .pc_write(b_pc_w), .if_id_write(b_ifid_w),
    .if_id_flush(b_ifid_f), .id_ex_write(b_idex_w), .id_ex_flush(b_idex_f),
    .ex_mem_bubble(b_bub), .state_o(b_st), .stall_cycles(b_stall),
    .flush_events(b_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // control vector packed as {pc_w, ifid_w, ifid_f, idex_w, idex_f, bubble}
  task automatic chk_a(input string tag, input logic [5:0] exp, input logic [1:0] st);
    chk({tag, "_a_ctl"}, {26'd0, a_pc_w, a_ifid_w, a_ifid_f, a_idex_w, a_idex_f, a_bub}, {26'd0, exp});
    chk({tag, "_a_st"}, {30'd0, a_st}, {30'd0, st});
  endtask

  task automatic chk_b(input string tag, input logic [5:0] exp, input logic [1:0] st);
    chk({tag, "_b_ctl"}, {26'd0, b_pc_w, b_ifid_w, b_ifid_f, b_idex_w, b_idex_f, b_bub}, {26'd0, exp});
    chk({tag, "_b_st"}, {30'd0, b_st}, {30'd0, st});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] as, input logic [31:0] af,
                         input logic [2:0] bs, input logic [2:0] bf);
    chk({tag, "_a_stall"}, a_stall, as);
    chk({tag, "_a_flush"}, a_flush, af);
    chk({tag, "_b_stall"}, {29'd0, b_stall}, {29'd0, bs});
    chk({tag, "_b_flush"}, {29'd0, b_flush}, {29'd0, bf});
  endtask

  task automatic idle();
    reset = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; ex_rd = 5'd0;
    ex_MemRead = 1'b0; branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0; mem_busy = 1'b0;
  endtask

  // advance to just after the next rising edge, then settle inputs mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] C_RUN   = 6'b110100;
  localparam logic [5:0] C_LU    = 6'b000110;
  localparam logic [5:0] C_HOLD  = 6'b000001;
  localparam logic [5:0] C_FRZ   = 6'b000000;
  localparam logic [5:0] C_FLUSH = 6'b111110;

  initial begin
    idle();
    reset = 1'b1;
    // hazard inputs present during reset must not reach the controls
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    tick(); #2;
    chk_a("rst", C_RUN, 2'd0);
    chk_b("rst", C_RUN, 2'd0);
    tick();
    idle(); #2;
    chk_cnt("rst_cnt", 32'd0, 32'd0, 3'd0, 3'd0);
    chk_a("run_idle", C_RUN, 2'd0);

    // ld x5 ; add x6,x5,x1
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1; id_uses_rs2 = 1'b1;
    #2;
    chk_a("lu1", C_LU, 2'd0);
    chk_b("lu1", C_LU, 2'd0);
    tick();
    idle(); #2;
    chk_a("lu2", C_RUN, 2'd0);
    chk_b("lu2", C_LU, 2'd1);
    chk_cnt("lu2_cnt", 32'd1, 32'd0, 3'd1, 3'd0);
    tick(); #2;
    chk_b("lu3", C_RUN, 2'd0);
    chk_cnt("lu3_cnt", 32'd1, 32'd0, 3'd2, 3'd0);

    // non-hazards: load to x0, and rs2 match with rs2 unused
    ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; #2;
    chk_a("x0", C_RUN, 2'd0);
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0; #2;
    chk_a("rs2_unused", C_RUN, 2'd0);
    id_uses_rs2 = 1'b1; #2;
    chk_a("rs2_used", C_LU, 2'd0);
    chk_b("rs2_used", C_LU, 2'd0);
    tick();
    idle(); branch_taken = 1'b1; #2;
    chk_b("br_lu", C_FLUSH, 2'd1);
    chk_a("br_run", C_FLUSH, 2'd0);
    tick();
    idle(); #2;
    chk_b("br_after", C_RUN, 2'd0);
    chk_cnt("br_cnt", 32'd2, 32'd1, 3'd3, 3'd1);

    // mc_start with done in the same cycle adds no stall
    mc_start = 1'b1; mc_done = 1'b1; #2;
    chk_a("mc_same", C_RUN, 2'd0);
    tick();
    idle(); #2;
    chk_a("mc_same_nx", C_RUN, 2'd0);

    // mc_start, two wait cycles frozen by mem_busy, done four cycles later
    mc_start = 1'b1; #2;
    chk_a("mc0", C_HOLD, 2'd0);
    tick();
    idle(); #2;
    chk_a("mc1", C_HOLD, 2'd2);
    chk_b("mc1", C_HOLD, 2'd2);
    tick();
    mem_busy = 1'b1; #2;
    chk_a("mc2_busy", C_FRZ, 2'd2);
    tick(); #2;
    chk_a("mc3_busy", C_FRZ, 2'd2);
    tick();
    idle(); mc_done = 1'b1; #2;
    chk_a("mc4_done", C_RUN, 2'd2);
    tick();
    idle(); #2;
    chk_a("mc_exit", C_RUN, 2'd0);
    chk_cnt("mc_cnt", 32'd6, 32'd1, 3'd7, 3'd1);

    // push the narrow counter past its ceiling, then reset mid MC_WAIT
    mc_start = 1'b1; #2;
    tick();
    idle(); #2;
    chk_cnt("sat1", 32'd7, 32'd1, 3'd7, 3'd1);
    tick(); #2;
    chk_cnt("sat2", 32'd8, 32'd1, 3'd7, 3'd1);
    chk_b("pre_rst", C_HOLD, 2'd2);
    reset = 1'b1; #2;
    chk_b("in_rst", C_RUN, 2'd2);
    tick();
    idle(); #2;
    chk_a("post_rst", C_RUN, 2'd0);
    chk_b("post_rst", C_RUN, 2'd0);
    chk_cnt("post_rst_cnt", 32'd0, 32'd0, 3'd0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
